apu_reg_writer: RTL and testbench

- Host-side register writer for the APU: turns a byte stream (from the UART/SPI byte receiver) into the APU register file and the per-channel change toggles that the sound channels consume.
- Each write is an address/data byte pair. Writes to a channel's length/period-high register flip that channel's change toggle. The consuming channel edge-detects the toggle after its own 2-flop synchroniser.
- Sits between the serial byte receiver and the pulse, triangle and noise channels.

---
 rtl/apu_reg_writer.sv | 168 ++++++++++++++++
 tb/tb_apu_reg_writer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/apu_reg_writer.sv
// Host-side APU register writer: decodes address/data byte pairs from the serial
// receiver into the APU register file and per-channel length-reload toggles.
module apu_reg_writer #(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned TO_WIDTH       = 13
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       rx_ready,
  output logic [7:0] reg_4000,
  output logic [7:0] reg_4001,
  output logic [7:0] reg_4002,
  output logic [7:0] reg_4003,
  output logic [7:0] reg_4004,
  output logic [7:0] reg_4005,
  output logic [7:0] reg_4006,
  output logic [7:0] reg_4007,
  output logic [7:0] reg_4008,
  output logic [7:0] reg_400A,
  output logic [7:0] reg_400B,
  output logic [7:0] reg_400C,
  output logic [7:0] reg_400E,
  output logic [7:0] reg_400F,
  output logic [7:0] reg_4015,
  output logic [7:0] reg_4017,
  output logic [3:0] reg_change,
  output logic [7:0] err_count
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned SLOT_W   = 4;

  logic [1:0]          state_q, state_d;
  logic [4:0]          addr_q, addr_d;
  logic [7:0]          data_q, data_d;
  logic [TO_WIDTH-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]          regs_q [NUM_REGS];
  logic [7:0]          regs_d [NUM_REGS];
  logic [3:0]          change_q, change_d;
  logic [7:0]          err_q, err_d;
  logic                rx_ready_q, rx_ready_d;

  logic                accept;
  logic                err_inc;
  logic                off_valid;
  logic [SLOT_W-1:0]   slot;
  logic                tog_hit;
  logic [1:0]          tog_idx;

  // Map the sparse register offset onto a dense storage slot and toggle index.
  always_comb begin
    off_valid = 1'b1;
    slot      = '0;
    tog_hit   = 1'b0;
    tog_idx   = '0;
    case (addr_q)
      5'h00, 5'h01, 5'h02, 5'h04, 5'h05, 5'h06, 5'h08: slot = addr_q[3:0];
      5'h03: begin slot = 4'd3;  tog_hit = 1'b1; tog_idx = 2'd0; end
      5'h07: begin slot = 4'd7;  tog_hit = 1'b1; tog_idx = 2'd1; end
      5'h0A: slot = 4'd9;
      5'h0B: begin slot = 4'd10; tog_hit = 1'b1; tog_idx = 2'd2; end
      5'h0C: slot = 4'd11;
      5'h0E: slot = 4'd12;
      5'h0F: begin slot = 4'd13; tog_hit = 1'b1; tog_idx = 2'd3; end
      5'h15: slot = 4'd14;
      5'h17: slot = 4'd15;
      default: off_valid = 1'b0;
    endcase
  end

  assign accept = rx_valid && rx_ready_q;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    to_cnt_d = to_cnt_q;
    regs_d   = regs_q;
    change_d = change_q;
    err_inc  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (rx_data[7]) begin
            addr_d   = rx_data[4:0];
            to_cnt_d = '0;
            state_d  = S_DATA;
          end else begin
            err_inc = 1'b1;
          end
        end
      end
      S_DATA: begin
        // An arriving data byte wins over the timeout on the same cycle.
        if (accept) begin
          data_d  = rx_data;
          state_d = S_COMMIT;
        end else if (to_cnt_q == TO_WIDTH'(TIMEOUT_CYCLES - 1)) begin
          err_inc = 1'b1;
          state_d = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_WIDTH'(1);
        end
      end
      S_COMMIT: begin
        if (off_valid) begin
          regs_d[slot] = data_q;
          if (tog_hit) change_d[tog_idx] = ~change_q[tog_idx];
        end else begin
          err_inc = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    err_d      = (err_inc && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
    rx_ready_d = (state_d != S_COMMIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      to_cnt_q   <= '0;
      change_q   <= '0;
      err_q      <= '0;
      rx_ready_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      to_cnt_q   <= to_cnt_d;
      change_q   <= change_d;
      err_q      <= err_d;
      rx_ready_q <= rx_ready_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign rx_ready   = rx_ready_q;
  assign reg_4000   = regs_q[0];
  assign reg_4001   = regs_q[1];
  assign reg_4002   = regs_q[2];
  assign reg_4003   = regs_q[3];
  assign reg_4004   = regs_q[4];
  assign reg_4005   = regs_q[5];
  assign reg_4006   = regs_q[6];
  assign reg_4007   = regs_q[7];
  assign reg_4008   = regs_q[8];
  assign reg_400A   = regs_q[9];
  assign reg_400B   = regs_q[10];
  assign reg_400C   = regs_q[11];
  assign reg_400E   = regs_q[12];
  assign reg_400F   = regs_q[13];
  assign reg_4015   = regs_q[14];
  assign reg_4017   = regs_q[15];
  assign reg_change = change_q;
  assign err_count  = err_q;

endmodule

// File: tb/tb_apu_reg_writer.sv
// Directed bench for apu_reg_writer: a table of register pairs plus hand-written
// sequences for latency, COMMIT back-pressure, timeout, saturation and reset.
module tb_apu_reg_writer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic [7:0] reg_4000, reg_4001, reg_4002, reg_4003;
  logic [7:0] reg_4004, reg_4005, reg_4006, reg_4007;
  logic [7:0] reg_4008, reg_400A, reg_400B;
  logic [7:0] reg_400C, reg_400E, reg_400F;
  logic [7:0] reg_4015, reg_4017;
  logic [3:0] reg_change;
  logic [7:0] err_count;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  apu_reg_writer #(.TIMEOUT_CYCLES(4096), .TO_WIDTH(13)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .reg_4000(reg_4000), .reg_4001(reg_4001), .reg_4002(reg_4002), .reg_4003(reg_4003),
    .reg_4004(reg_4004), .reg_4005(reg_4005), .reg_4006(reg_4006), .reg_4007(reg_4007),
    .reg_4008(reg_4008), .reg_400A(reg_400A), .reg_400B(reg_400B),
    .reg_400C(reg_400C), .reg_400E(reg_400E), .reg_400F(reg_400F),
    .reg_4015(reg_4015), .reg_4017(reg_4017),
    .reg_change(reg_change), .err_count(err_count)
  );

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic [4:0] off;
    logic [7:0] exp_val;
    logic [3:0] exp_chg;
  } vec_t;

  vec_t vecs [12];
  logic [4:0] valid_offs [16];

  function automatic logic [7:0] get_reg(input logic [4:0] off);
    case (off)
      5'h00: return reg_4000;
      5'h01: return reg_4001;
      5'h02: return reg_4002;
      5'h03: return reg_4003;
      5'h04: return reg_4004;
      5'h05: return reg_4005;
      5'h06: return reg_4006;
      5'h07: return reg_4007;
      5'h08: return reg_4008;
      5'h0A: return reg_400A;
      5'h0B: return reg_400B;
      5'h0C: return reg_400C;
      5'h0E: return reg_400E;
      5'h0F: return reg_400F;
      5'h15: return reg_4015;
      5'h17: return reg_4017;
      default: return 8'h00;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Present a byte and hold it until accepted; returns #1 after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int waitc;
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    waitc    = 0;
    while (!rx_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    if (!rx_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_wait: byte 0x%0h never accepted", b);
      rx_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_pair(input logic [7:0] a, input logic [7:0] d);
    send_byte(a);
    send_byte(d);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string name);
    for (int i = 0; i < 16; i++) chk(name, 32'(get_reg(valid_offs[i])), 32'h0);
  endtask

  initial begin
    int exp_err;
    logic [4:0] untouched [6];

    valid_offs = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07,
                   5'h08, 5'h0A, 5'h0B, 5'h0C, 5'h0E, 5'h0F, 5'h15, 5'h17};
    vecs[0]  = '{8'h8B, 8'h7A, 5'h0B, 8'h7A, 4'b0000};
    vecs[1]  = '{8'h88, 8'hC3, 5'h08, 8'hC3, 4'b0000};
    vecs[2]  = '{8'h95, 8'h0F, 5'h15, 8'h0F, 4'b0000};
    vecs[3]  = '{8'h83, 8'h55, 5'h03, 8'h55, 4'b0001};
    vecs[4]  = '{8'h83, 8'h55, 5'h03, 8'h55, 4'b0000};
    vecs[5]  = '{8'h97, 8'hC0, 5'h17, 8'hC0, 4'b0000};
    vecs[6]  = '{8'h8F, 8'hAA, 5'h0F, 8'hAA, 4'b1000};
    vecs[7]  = '{8'hE7, 8'h3C, 5'h07, 8'h3C, 4'b1010};
    vecs[8]  = '{8'h80, 8'h01, 5'h00, 8'h01, 4'b1010};
    vecs[9]  = '{8'h8E, 8'hFF, 5'h0E, 8'hFF, 4'b1010};
    vecs[10] = '{8'h8B, 8'h00, 5'h0B, 8'h00, 4'b1110};
    vecs[11] = '{8'h84, 8'h99, 5'h04, 8'h99, 4'b1110};
    untouched = '{5'h01, 5'h02, 5'h05, 5'h06, 5'h0A, 5'h0C};

    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    exp_err  = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rx_ready", 32'(rx_ready), 32'h0);
    chk("rst_change", 32'(reg_change), 32'h0);
    chk("rst_err", 32'(err_count), 32'h0);
    chk_all_zero("rst_reg");
    @(negedge clk);
    rst_n = 1'b1;

    // First pair: latency and COMMIT back-pressure on a queued stray byte.
    send_byte(8'h8B);
    send_byte(8'h7A);
    chk("lat_before_reg", 32'(reg_400B), 32'h0);
    chk("lat_before_chg", 32'(reg_change), 32'h0);
    chk("commit_not_ready", 32'(rx_ready), 32'h0);
    @(posedge clk);
    #1;
    chk("lat_after_reg", 32'(reg_400B), 32'h7A);
    chk("lat_after_chg", 32'(reg_change), 32'b0100);
    chk("lat_others_4003", 32'(reg_4003), 32'h0);
    chk("lat_others_4008", 32'(reg_4008), 32'h0);
    chk("idle_ready", 32'(rx_ready), 32'h1);

    send_byte(8'h45);
    exp_err++;
    chk("stray_err", 32'(err_count), 32'(exp_err));

    // Invalid offset 0x09: nothing written, error counted.
    send_pair(8'h89, 8'h11);
    exp_err++;
    chk("inval_err", 32'(err_count), 32'(exp_err));
    chk("inval_chg", 32'(reg_change), 32'b0100);
    chk("inval_4008", 32'(reg_4008), 32'h0);

    for (int i = 0; i < 12; i++) begin
      send_pair(vecs[i].addr, vecs[i].data);
      chk($sformatf("vec%0d_reg", i), 32'(get_reg(vecs[i].off)), 32'(vecs[i].exp_val));
      chk($sformatf("vec%0d_chg", i), 32'(reg_change), 32'(vecs[i].exp_chg));
      chk($sformatf("vec%0d_err", i), 32'(err_count), 32'(exp_err));
    end
    for (int i = 0; i < 6; i++) chk("untouched", 32'(get_reg(untouched[i])), 32'h0);

    // Timeout: expires on the 4096th edge after the address accept.
    send_byte(8'h83);
    repeat (4095) @(posedge clk);
    #1;
    chk("to_not_yet", 32'(err_count), 32'(exp_err));
    @(posedge clk);
    #1;
    exp_err++;
    chk("to_fired", 32'(err_count), 32'(exp_err));
    repeat (900) @(posedge clk);
    send_byte(8'h22);
    exp_err++;
    chk("to_stray_err", 32'(err_count), 32'(exp_err));
    chk("to_4003", 32'(reg_4003), 32'h55);
    chk("to_chg", 32'(reg_change), 32'b1110);

    // Data arriving on the last cycle before expiry still commits.
    send_byte(8'h8C);
    repeat (4094) @(posedge clk);
    send_byte(8'h5A);
    @(posedge clk);
    #1;
    chk("to_edge_reg", 32'(reg_400C), 32'h5A);
    chk("to_edge_err", 32'(err_count), 32'(exp_err));

    for (int i = 0; i < 260; i++) send_byte(8'h01);
    chk("err_sat", 32'(err_count), 32'hFF);

    // Reset between an address and its data byte.
    send_byte(8'h87);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_chg", 32'(reg_change), 32'h0);
    chk("mid_rst_err", 32'(err_count), 32'h0);
    chk("mid_rst_ready", 32'(rx_ready), 32'h0);
    chk_all_zero("mid_rst_reg");
    @(negedge clk);
    rst_n = 1'b1;
    send_pair(8'h87, 8'h10);
    chk("post_rst_4007", 32'(reg_4007), 32'h10);
    chk("post_rst_chg", 32'(reg_change), 32'b0010);
    chk("post_rst_err", 32'(err_count), 32'h0);
    chk("post_rst_400B", 32'(reg_400B), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
